des_ip_loader: RTL and testbench

- Input-side counterpart of the DES final permutation stage.
- Takes the plaintext/ciphertext byte stream from the stream front end and assembles it into 64-bit blocks.
- Applies the DES Initial Permutation (IP) to each block and hands L0/R0 to the round engine over a valid/ready handshake.
- Sits between the compression output stream and the DES round core.

---
 rtl/des_pkg.sv | 31 +++
 rtl/des_initial_permutation.sv | 13 +
 rtl/des_ip_loader.sv | 128 ++++++++++++
 tb/tb_des_ip_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES permutation constants and the loader FSM encoding.
// Table entries are 1-based with entry 1 meaning the block MSB.
package des_pkg;

    localparam int BLK_W = 64;

    localparam logic [0:63][6:0] IP_TAB = {
        7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
        7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
        7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
        7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
        7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
        7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
    };

    localparam logic [0:63][6:0] FP_TAB = {
        7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
        7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
        7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
        7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
        7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
        7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
        7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
        7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
    };

    typedef enum logic {COLLECT, PAD} fsm_t;

endpackage

// File: rtl/des_initial_permutation.sv
// Combinational DES Initial Permutation; pure wiring driven by IP_TAB.
module des_initial_permutation
    import des_pkg::*;
(
    input  logic [BLK_W-1:0] blk,
    output logic [BLK_W-1:0] perm
);

    for (genvar k = 0; k < BLK_W; k++) begin : g_ip
        assign perm[BLK_W-1-k] = blk[BLK_W-IP_TAB[k]];
    end

endmodule

// File: rtl/des_ip_loader.sv
// Byte-to-block assembler feeding the DES round core with IP(L0,R0).
// Define DES_LOADER_PAD_EN to enable PKCS#5 padding on in_last.
module des_ip_loader
    import des_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    output logic [31:0]      out_l,
    output logic [31:0]      out_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] blk_cnt
);

    fsm_t             state, state_nx;
    logic [2:0]       cnt, cnt_nx;
    logic             started;
    logic [BLK_W-1:0] asm_q, asm_nx, perm;
    logic [7:0]       byte_in;
    logic             xfer, stall, full_stall, load;

    assign stall      = out_valid && !out_ready;
    assign full_stall = (cnt == 3'd7) && stall;
    assign in_ready   = started && (state == COLLECT) && !full_stall;
    assign load       = xfer && (cnt == 3'd7);

`ifdef DES_LOADER_PAD_EN
    logic [3:0] pad_val, pad_nx;
    logic       last_nx, last_q;

    // Pad bytes obey the same full-output stall as real bytes.
    assign byte_in  = (state == PAD) ? {4'd0, pad_val} : in_data;
    assign xfer     = (state == PAD) ? !full_stall : (in_valid && in_ready);
    assign out_last = last_q;
`else
    logic unused_last;

    assign unused_last = in_last;
    assign byte_in     = in_data;
    assign xfer        = in_valid && in_ready;
    assign out_last    = 1'b0;
`endif

    // ~cnt == 7-cnt, so the first byte lands in [63:56] when MSB_FIRST.
    always_comb begin
        asm_nx = asm_q;
        if (MSB_FIRST) asm_nx[{~cnt, 3'b000} +: 8] = byte_in;
        else           asm_nx[{cnt, 3'b000} +: 8]  = byte_in;
    end

    des_initial_permutation u_ip (.blk(asm_nx), .perm(perm));

    always_comb begin
        state_nx = state;
        cnt_nx   = xfer ? cnt + 3'd1 : cnt;
`ifdef DES_LOADER_PAD_EN
        pad_nx  = pad_val;
        last_nx = 1'b0;
        if (state == COLLECT && xfer && in_last) begin
            state_nx = PAD;
            // A last byte that fills the block schedules a whole block of 8s.
            pad_nx   = (cnt == 3'd7) ? 4'd8 : {1'b0, 3'd7 - cnt};
        end
        if (state == PAD && load) begin
            state_nx = COLLECT;
            last_nx  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= COLLECT;
            cnt     <= 3'd0;
            started <= 1'b0;
            asm_q   <= '0;
`ifdef DES_LOADER_PAD_EN
            pad_val <= 4'd0;
`endif
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            started <= 1'b1;
            if (xfer) asm_q <= asm_nx;
`ifdef DES_LOADER_PAD_EN
            pad_val <= pad_nx;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_l     <= '0;
            out_r     <= '0;
            out_valid <= 1'b0;
            blk_cnt   <= '0;
`ifdef DES_LOADER_PAD_EN
            last_q    <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) blk_cnt <= blk_cnt + 1'b1;
            // A block completing on the hand-off edge replaces the old one.
            if (load) begin
                {out_l, out_r} <= perm;
                out_valid      <= 1'b1;
`ifdef DES_LOADER_PAD_EN
                last_q         <= last_nx;
`endif
            end else if (out_valid && out_ready) begin
                out_l     <= '0;
                out_r     <= '0;
                out_valid <= 1'b0;
`ifdef DES_LOADER_PAD_EN
                last_q    <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_des_ip_loader.sv
// Directed bench for des_ip_loader: MSB-first (CNT_W=4) and LSB-first instances.
module tb_des_ip_loader;
    import des_pkg::*;

    logic        clk, rst_n;
    logic [7:0]  in_data;
    logic        in_valid, in_last, out_ready;
    logic        in_ready, out_valid, out_last;
    logic [31:0] out_l, out_r;
    logic [3:0]  blk_cnt;
    logic        l_ready, l_valid, l_last;
    logic [31:0] l_l, l_r, l_cnt;

    int tests = 0;
    int fails = 0;

    des_ip_loader #(.CNT_W(4), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .out_l(out_l), .out_r(out_r),
        .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .blk_cnt(blk_cnt));

    des_ip_loader #(.CNT_W(32), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(l_ready), .in_last(in_last), .out_l(l_l), .out_r(l_r),
        .out_valid(l_valid), .out_ready(out_ready), .out_last(l_last),
        .blk_cnt(l_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] fp(input logic [63:0] x);
        logic [63:0] y;
        for (int k = 0; k < 64; k++) y[63-k] = x[64-FP_TAB[k]];
        return y;
    endfunction

    function automatic logic [63:0] bswap(input logic [63:0] x);
        return {<<8{x}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Both instances must hold a block whose FP recovers the assembled input.
    task automatic check_blk(input string tag, input logic [63:0] exp);
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_msb_rt"}, fp({out_l, out_r}), exp);
        chk({tag, "_lsb_valid"}, {63'd0, l_valid}, 64'd1);
        chk({tag, "_lsb_rt"}, fp({l_l, l_r}), bswap(exp));
    endtask

    task automatic push(input logic [7:0] b, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = b; in_last = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic push_blk(input logic [63:0] v, input logic last);
        for (int i = 0; i < 8; i++) push(v[63-8*i -: 8], last && (i == 7));
    endtask

    task automatic wait_valid();
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) chk("wait_valid_timeout", {63'd0, out_valid}, 64'd1);
    endtask

    initial begin
        logic [63:0] v;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out", {out_l, out_r}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_blk_cnt", {60'd0, blk_cnt}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Known-answer block
        out_ready = 1'b1;
        push_blk(64'h0123456789ABCDEF, 1'b0);
        @(negedge clk);
        chk("kat_out", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        check_blk("kat", 64'h0123456789ABCDEF);
        @(negedge clk);
        chk("kat_handoff_valid", {63'd0, out_valid}, 64'd0);
        chk("kat_blk_cnt", {60'd0, blk_cnt}, 64'd1);

        // Back-to-back under backpressure
        out_ready = 1'b0;
        push_blk(64'hFFFFFFFF00000000, 1'b0);
        @(negedge clk);
        chk("bp_a_out", {out_l, out_r}, 64'h0F0F0F0F_0F0F0F0F);
        for (int i = 0; i < 7; i++) push(8'(8'h01 + 8'h22 * i), 1'b0);
        @(negedge clk);
        chk("bp_a_held", {out_l, out_r}, 64'h0F0F0F0F_0F0F0F0F);
        in_valid = 1'b1; in_data = 8'hEF;
        #1 chk("bp_8th_blocked", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        chk("bp_8th_still_blocked", {63'd0, in_ready}, 64'd0);
        chk("bp_a_still_held", {out_l, out_r}, 64'h0F0F0F0F_0F0F0F0F);
        out_ready = 1'b1;
        #1 chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_b_no_bubble", {63'd0, out_valid}, 64'd1);
        chk("bp_b_out", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        chk("bp_blk_cnt_a", {60'd0, blk_cnt}, 64'd2);
        @(negedge clk);
        chk("bp_blk_cnt_b", {60'd0, blk_cnt}, 64'd3);

        // Random round trip through FP
        for (int i = 0; i < 1000; i++) begin
            v = {$urandom, $urandom};
            push_blk(v, 1'b0);
            @(negedge clk);
            check_blk("rt", v);
        end
        @(negedge clk);
        chk("rt_blk_cnt", {60'd0, blk_cnt}, 64'd11);

        // Reset mid-block
        out_ready = 1'b0;
        push_blk(64'hFFFFFFFF00000000, 1'b0);
        for (int i = 0; i < 5; i++) push(8'(8'h11 * (i + 1)), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_out", {out_l, out_r}, 64'd0);
        chk("mid_rst_cnt", {60'd0, blk_cnt}, 64'd0);
        chk("mid_rst_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        push_blk(64'h0123456789ABCDEF, 1'b0);
        @(negedge clk);
        chk("post_rst_out", {out_l, out_r}, 64'hCC00CCFF_F0AAF0AA);
        check_blk("post_rst", 64'h0123456789ABCDEF);

`ifdef DES_LOADER_PAD_EN
        push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b1);
        @(negedge clk);
        chk("pad_in_ready_low", {63'd0, in_ready}, 64'd0);
        wait_valid();
        check_blk("pad3", 64'hAABBCC0505050505);
        chk("pad3_last", {63'd0, out_last}, 64'd1);
        chk("pad3_lsb_last", {63'd0, l_last}, 64'd1);
        chk("pad3_in_ready", {63'd0, in_ready}, 64'd1);
        push_blk(64'h1122334455667788, 1'b1);
        @(negedge clk);
        check_blk("pad8_data", 64'h1122334455667788);
        chk("pad8_data_last", {63'd0, out_last}, 64'd0);
        @(posedge clk);
        wait_valid();
        check_blk("pad8_fill", 64'h0808080808080808);
        chk("pad8_fill_last", {63'd0, out_last}, 64'd1);
`else
        push(8'hAA, 1'b0); push(8'hBB, 1'b0); push(8'hCC, 1'b1);
        repeat (3) @(negedge clk);
        chk("nopad_partial_held", {63'd0, out_valid}, 64'd0);
        chk("nopad_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b0);
        @(negedge clk);
        check_blk("nopad_blk", 64'hAABBCC0102030405);
        chk("nopad_last", {63'd0, out_last}, 64'd0);
`endif

        // blk_cnt wrap at CNT_W=4
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_blk({$urandom, $urandom}, 1'b0);
            @(negedge clk);
            chk("wrap_cnt", {60'd0, blk_cnt}, 64'(i));
        end
        @(negedge clk);
        chk("wrap_zero", {60'd0, blk_cnt}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
